// File: rtl/biquad_cascade_sequencer_if.sv
// Staging-write, commit and filter-configuration signals shared by the
// biquad cascade sequencer and whoever drives it.
interface biquad_cascade_sequencer_if;
    logic         wr_en;
    logic [2:0]   wr_section;
    logic [2:0]   wr_index;
    logic [31:0]  wr_data;
    logic         commit;
    logic [15:0]  decim_n;
    logic         wr_ready;
    logic         busy;
    logic         wr_err;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         axis_decii_clk;

    modport master (
        output wr_en, wr_section, wr_index, wr_data, commit, decim_n,
        input  wr_ready, busy, wr_err, config_addr, config_data, axis_decii_clk
    );

    modport slave (
        input  wr_en, wr_section, wr_index, wr_data, commit, decim_n,
        output wr_ready, busy, wr_err, config_addr, config_data, axis_decii_clk
    );
endinterface

// File: rtl/biquad_cascade_sequencer.sv
// Stages biquad coefficients, pushes them section by section onto the config
// bus on commit, waits out a settle window, then issues the decimation strobe.
module biquad_cascade_sequencer #(
    parameter int          NUM_SECTIONS  = 4,
    parameter logic [31:0] BASE_ADDRESS  = 32'd1000,
    parameter logic [31:0] IDLE_ADDRESS  = 32'd0,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [31:0] COEF_ONE      = 32'h0FFF_FFFF
) (
    input  logic                      aclk,
    input  logic                      reset,
    biquad_cascade_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    localparam logic [3:0]  LAST_SECTION = 4'(NUM_SECTIONS - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);

    state_t       state;
    logic [31:0]  staging [8][6];
    logic [3:0]   section;
    logic [15:0]  settle_count;
    logic [15:0]  decim_count;
    logic [15:0]  decim_period;
    logic         pending;
    logic         auto_commit;
    logic         ready_q;
    logic         busy_q;
    logic         err_q;
    logic [31:0]  addr_q;
    logic [511:0] data_q;
    logic         strobe_q;

    logic         write_ok;
    logic         start_load;
    logic [15:0]  decim_sample;
    logic [2:0]   load_sel;
    logic [511:0] load_data;

    assign write_ok = bus.wr_en && ready_q &&
                      ({1'b0, bus.wr_section} <= LAST_SECTION) &&
                      (bus.wr_index <= 3'd5);
    assign decim_sample = (bus.decim_n == 16'd0) ? 16'd1 : bus.decim_n;

    assign bus.wr_ready       = ready_q;
    assign bus.busy           = busy_q;
    assign bus.wr_err         = err_q;
    assign bus.config_addr    = addr_q;
    assign bus.config_data    = data_q;
    assign bus.axis_decii_clk = strobe_q;

    always_comb begin
        start_load = 1'b0;
        case (state)
            IDLE:    start_load = bus.commit || auto_commit;
            SETTLE:  start_load = (settle_count == SETTLE_LAST) && (pending || bus.commit);
            RUN:     start_load = bus.commit;
            default: start_load = 1'b0;
        endcase
    end

    // The write accepted in the same cycle as a commit is forwarded so section 0 carries it.
    always_comb begin
        load_sel  = 3'd0;
        load_data = '0;
        if (state == LOAD && section <= LAST_SECTION)
            load_sel = section[2:0];
        for (int k = 0; k < 6; k++) begin
            load_data[32*k +: 32] = staging[load_sel][k];
            if (write_ok && bus.wr_section == load_sel && bus.wr_index == 3'(k))
                load_data[32*k +: 32] = bus.wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state        <= IDLE;
            section      <= 4'd0;
            settle_count <= 16'd0;
            decim_count  <= 16'd0;
            decim_period <= 16'd1;
            pending      <= 1'b0;
            auto_commit  <= 1'b1;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= IDLE_ADDRESS;
            data_q       <= '0;
            strobe_q     <= 1'b0;
            for (int s = 0; s < 8; s++)
                for (int k = 0; k < 6; k++)
                    staging[s][k] <= (k == 0) ? COEF_ONE : 32'd0;
        end else begin
            if (write_ok)
                staging[bus.wr_section][bus.wr_index] <= bus.wr_data;
            if (bus.wr_en && !write_ok)
                err_q <= 1'b1;

            addr_q   <= IDLE_ADDRESS;
            data_q   <= '0;
            strobe_q <= 1'b0;

            if ((state == LOAD || state == SETTLE) && bus.commit)
                pending <= 1'b1;

            // Entering LOAD already emits section 0, so the bus trails commit by one cycle.
            if (start_load) begin
                state       <= LOAD;
                auto_commit <= 1'b0;
                pending     <= 1'b0;
                section     <= 4'd1;
                addr_q      <= BASE_ADDRESS;
                data_q      <= load_data;
                ready_q     <= 1'b0;
                busy_q      <= 1'b1;
                decim_count <= 16'd0;
            end else begin
                case (state)
                    LOAD: begin
                        if (section > LAST_SECTION) begin
                            state        <= SETTLE;
                            settle_count <= 16'd0;
                        end else begin
                            addr_q  <= BASE_ADDRESS + {28'd0, section};
                            data_q  <= load_data;
                            section <= section + 4'd1;
                        end
                    end
                    SETTLE: begin
                        if (settle_count == SETTLE_LAST) begin
                            state        <= RUN;
                            ready_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            decim_count  <= 16'd0;
                            decim_period <= decim_sample;
                        end else begin
                            settle_count <= settle_count + 16'd1;
                        end
                    end
                    RUN: begin
                        if (decim_count == decim_period - 16'd1) begin
                            strobe_q     <= 1'b1;
                            decim_count  <= 16'd0;
                            decim_period <= decim_sample;
                        end else begin
                            decim_count <= decim_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Directed bench for biquad_cascade_sequencer: a phase-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_biquad_cascade_sequencer;
    localparam int          NSEC     = 4;
    localparam logic [31:0] BASE     = 32'd1000;
    localparam int          SETTLE   = 4;
    localparam logic [31:0] COEF_ONE = 32'h0FFF_FFFF;

    logic aclk  = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    biquad_cascade_sequencer_if bus();

    biquad_cascade_sequencer #(
        .NUM_SECTIONS (NSEC),
        .BASE_ADDRESS (BASE),
        .IDLE_ADDRESS (32'd0),
        .SETTLE_CYCLES(SETTLE),
        .COEF_ONE     (COEF_ONE)
    ) dut (
        .aclk (aclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 aclk = ~aclk;

    typedef enum {M_IDLE, M_LOAD, M_SETTLE, M_RUN} mode_t;

    mode_t        m_mode;
    int           m_t;
    int           m_age;
    int           m_period;
    bit           m_pend;
    bit           m_auto;
    logic [31:0]  m_stage [8][6];
    logic [31:0]  m_snap  [8][6];
    logic [31:0]  e_addr;
    logic [511:0] e_data;
    logic         e_busy, e_ready, e_err, e_strobe;

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model works from phase ages: cycles since a load began, since RUN entry or the last strobe.
    task automatic model_step();
        bit accept;
        bit start;
        if (reset) begin
            m_mode = M_IDLE; m_t = 0; m_age = 0; m_period = 1;
            m_pend = 0; m_auto = 1;
            for (int s = 0; s < 8; s++)
                for (int k = 0; k < 6; k++)
                    m_stage[s][k] = (k == 0) ? COEF_ONE : 32'd0;
            e_addr = 32'd0; e_data = '0; e_busy = 0; e_ready = 0; e_err = 0; e_strobe = 0;
            return;
        end
        accept = bus.wr_en && e_ready && (int'(bus.wr_section) < NSEC) && (bus.wr_index <= 3'd5);
        if (bus.wr_en && !accept) e_err = 1;
        if (accept) m_stage[bus.wr_section][bus.wr_index] = bus.wr_data;
        e_strobe = 0;
        start    = 0;
        case (m_mode)
            M_IDLE: start = bus.commit || m_auto;
            M_LOAD: begin
                if (bus.commit) m_pend = 1;
                m_t++;
                if (m_t == NSEC) begin m_mode = M_SETTLE; m_t = 0; end
            end
            M_SETTLE: begin
                if (bus.commit) m_pend = 1;
                m_t++;
                if (m_t == SETTLE) begin
                    if (m_pend) start = 1;
                    else begin
                        m_mode = M_RUN; m_age = 0;
                        m_period = (bus.decim_n == 16'd0) ? 1 : int'(bus.decim_n);
                    end
                end
            end
            M_RUN: begin
                if (bus.commit) start = 1;
                else begin
                    m_age++;
                    if (m_age == m_period) begin
                        e_strobe = 1; m_age = 0;
                        m_period = (bus.decim_n == 16'd0) ? 1 : int'(bus.decim_n);
                    end
                end
            end
            default: ;
        endcase
        if (start) begin
            m_mode = M_LOAD; m_t = 0; m_pend = 0; m_auto = 0;
            m_snap = m_stage;
        end
        e_busy  = (m_mode == M_LOAD) || (m_mode == M_SETTLE);
        e_ready = (m_mode == M_RUN);
        e_addr  = (m_mode == M_LOAD) ? BASE + 32'(m_t) : 32'd0;
        e_data  = '0;
        if (m_mode == M_LOAD)
            for (int k = 0; k < 6; k++) e_data[32*k +: 32] = m_snap[m_t][k];
    endtask

    always begin
        @(posedge aclk);
        model_step();
        #1;
        check_output("config_addr", 512'(bus.config_addr), 512'(e_addr));
        check_output("config_data", bus.config_data, e_data);
        check_output("busy", 512'(bus.busy), 512'(e_busy));
        check_output("wr_ready", 512'(bus.wr_ready), 512'(e_ready));
        check_output("wr_err", 512'(bus.wr_err), 512'(e_err));
        check_output("axis_decii_clk", 512'(bus.axis_decii_clk), 512'(e_strobe));
    end

    task automatic apply_stimulus(input logic [2:0] sec, input logic [2:0] idx,
                                  input logic [31:0] data, input logic en, input logic cmt);
        bus.wr_en = en; bus.wr_section = sec; bus.wr_index = idx; bus.wr_data = data; bus.commit = cmt;
        @(negedge aclk);
        bus.wr_en = 1'b0; bus.commit = 1'b0;
    endtask

    task automatic wait_strobe(input string name, output int gap);
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge aclk);
            if (bus.axis_decii_clk) begin gap = i; break; end
        end
        if (gap == 0) begin
            checks++; errors++;
            $display("[TB] FAIL %s: no strobe within 40 cycles", name);
        end
    endtask

    task automatic wait_addr(input logic [31:0] target);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.config_addr == target) seen = 1;
            else @(negedge aclk);
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL wait_addr: address %0d never appeared", target);
        end
    endtask

    task automatic count_busy(input int already, output int total);
        total = already;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (!bus.busy) break;
            total++;
            if (bus.config_addr == BASE + 32'd1)
                check_output("reload sec1 b0", 512'(bus.config_data[31:0]), 512'(COEF_ONE));
        end
    endtask

    initial begin
        int gap;
        int busy_total;
        bus.wr_en = 1'b0; bus.wr_section = 3'd0; bus.wr_index = 3'd0; bus.wr_data = 32'd0;
        bus.commit = 1'b0; bus.decim_n = 16'd5;
        reset = 1'b1;
        repeat (3) @(negedge aclk);
        check_output("reset addr", 512'(bus.config_addr), 512'(0));
        check_output("reset busy", 512'(bus.busy), 512'(0));
        check_output("reset ready", 512'(bus.wr_ready), 512'(0));
        check_output("reset strobe", 512'(bus.axis_decii_clk), 512'(0));

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check_output("auto-load addr", 512'(bus.config_addr), 512'(1000 + i));
            check_output("auto-load b0", 512'(bus.config_data[31:0]), 512'(32'h0FFF_FFFF));
        end
        check_output("auto-load slot1", 512'(bus.config_data[63:32]), 512'(0));
        count_busy(4, busy_total);
        check_output("load+settle length", 512'(busy_total), 512'(8));

        wait_strobe("first strobe", gap);
        check_output("first strobe delay", 512'(gap), 512'(5));
        bus.decim_n = 16'd0;
        wait_strobe("period 5", gap);
        check_output("strobe period 5", 512'(gap), 512'(5));
        wait_strobe("period 1a", gap);
        check_output("strobe period 1a", 512'(gap), 512'(1));
        wait_strobe("period 1b", gap);
        check_output("strobe period 1b", 512'(gap), 512'(1));

        check_output("err clean", 512'(bus.wr_err), 512'(0));
        apply_stimulus(3'd5, 3'd0, 32'h0000_0055, 1'b1, 1'b0);
        check_output("err bad section", 512'(bus.wr_err), 512'(1));

        apply_stimulus(3'd2, 3'd4, 32'hF000_0000, 1'b1, 1'b0);
        apply_stimulus(3'd0, 3'd1, 32'h1234_5678, 1'b1, 1'b1);
        check_output("commit addr", 512'(bus.config_addr), 512'(1000));
        check_output("same-cycle write", 512'(bus.config_data[63:32]), 512'(32'h1234_5678));
        @(negedge aclk);
        apply_stimulus(3'd1, 3'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_output("third load addr", 512'(bus.config_addr), 512'(1002));
        check_output("sec2 a1", 512'(bus.config_data[159:128]), 512'(32'hF000_0000));
        count_busy(3, busy_total);
        check_output("double load length", 512'(busy_total), 512'(16));

        bus.decim_n = 16'd3;
        apply_stimulus(3'd0, 3'd0, 32'd0, 1'b0, 1'b1);
        check_output("pre-abort addr", 512'(bus.config_addr), 512'(1000));
        repeat (2) @(negedge aclk);
        check_output("abort point", 512'(bus.config_addr), 512'(1002));
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        check_output("abort addr", 512'(bus.config_addr), 512'(0));
        check_output("abort busy", 512'(bus.busy), 512'(0));
        check_output("abort strobe", 512'(bus.axis_decii_clk), 512'(0));
        check_output("abort err", 512'(bus.wr_err), 512'(0));
        @(negedge aclk);
        check_output("reload addr", 512'(bus.config_addr), 512'(1000));
        check_output("reload slot1", 512'(bus.config_data[63:32]), 512'(0));
        wait_addr(BASE + 32'd2);
        check_output("reload sec2 a1", 512'(bus.config_data[159:128]), 512'(0));
        count_busy(3, busy_total);
        check_output("reload length", 512'(busy_total), 512'(8));
        apply_stimulus(3'd1, 3'd7, 32'h0000_0066, 1'b1, 1'b0);
        check_output("err bad index", 512'(bus.wr_err), 512'(1));
        wait_strobe("period 3", gap);
        wait_strobe("period 3", gap);
        check_output("strobe period 3", 512'(gap), 512'(3));
        repeat (10) @(negedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/biquad_cascade_sequencer.md
BIQUAD_CASCADE_SEQUENCER -- requirements
Module: biquad_cascade_sequencer

Interface
REQ-001 Parameter NUM_SECTIONS, default 4, number of cascaded biquad sections configured (1..8).
REQ-002 Parameter BASE_ADDRESS, default 1000, config address of section 0; section s uses BASE_ADDRESS+s.
REQ-003 Parameter IDLE_ADDRESS, default 0, config_addr value driven when no section is being written.
REQ-004 Parameter SETTLE_CYCLES, default 4, aclk cycles of strobe hold-off after the last section write.
REQ-005 Parameter COEF_ONE, default 2^28-1, reset value of b0 (unity gain at Q28).
REQ-006 aclk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  one-cycle coefficient write strobe.
REQ-009 wr_section  in  3  target section index.
REQ-010 wr_index  in  3  coefficient slot: 0=b0,1=b1,2=b2,3=a0,4=a1,5=a2.
REQ-011 wr_data  in  32  signed coefficient value.
REQ-012 commit  in  1  one-cycle request to push staged coefficients to the filters.
REQ-013 decim_n  in  16  decimation ratio; 0 treated as 1.
REQ-014 wr_ready  out  1  high when staging writes are accepted.
REQ-015 busy  out  1  high while loading or settling.
REQ-016 wr_err  out  1  sticky flag: illegal or rejected write occurred; cleared only by reset.
REQ-017 config_addr  out  32  registered configuration address bus to the filter sections.
REQ-018 config_data  out  512  registered configuration data; slot k in bits [32k+31:32k].
REQ-019 axis_decii_clk  out  1  registered one-cycle decimation strobe to all sections.

Function
REQ-020 Staging table SHALL hold NUM_SECTIONS x 6 words; write when wr_en & wr_ready & wr_section<NUM_SECTIONS & wr_index<=5, visible to next load.
REQ-021 Write with wr_section>=NUM_SECTIONS, wr_index>5, or wr_ready low SHALL be dropped and set wr_err.
REQ-022 FSM states IDLE, LOAD, SETTLE, RUN; wr_ready=1 only in IDLE and RUN; busy=1 only in LOAD and SETTLE.
REQ-023 IDLE->LOAD on commit; RUN->LOAD on commit; LOAD->SETTLE after section NUM_SECTIONS-1 written; SETTLE->RUN after SETTLE_CYCLES cycles.
REQ-024 In LOAD, section s SHALL be written in cycle s of LOAD: config_addr=BASE_ADDRESS+s, config_data slots 0..5 = staged words, slots 6..15 = 0; exactly one cycle per section, ascending order.
REQ-025 Outside LOAD config_addr SHALL equal IDLE_ADDRESS and config_data SHALL be 0.
REQ-026 Write+commit in same cycle: write SHALL land in staging before load starts and be included.
REQ-027 Commit during LOAD or SETTLE SHALL set a pending flag; on leaving SETTLE with pending set, FSM SHALL re-enter LOAD (pending cleared) instead of RUN.
REQ-028 axis_decii_clk SHALL be 0 in IDLE, LOAD, SETTLE.
REQ-029 In RUN a 16-bit counter starts at 0 on RUN entry; strobe high when counter==N-1 (N=max(decim_n,1)), then counter wraps to 0; period N cycles, first strobe N cycles after RUN entry.
REQ-030 decim_n SHALL be sampled at RUN entry and at each wrap; mid-period changes take effect on the next period.
REQ-031 Leaving RUN on commit SHALL drop the strobe the same cycle and clear the counter.
REQ-032 All outputs registered; config bus latency from commit to first section address = 1 cycle.

Reset
REQ-033 During reset: state IDLE, config_addr=IDLE_ADDRESS, config_data=0, axis_decii_clk=0, busy=0, wr_ready=0, wr_err=0, pending=0, counter=0.
REQ-034 Reset SHALL load staging with b0=COEF_ONE, all other words 0 for every section.
REQ-035 First cycle after reset deassertion SHALL enter LOAD automatically (implicit commit of defaults).
REQ-036 Reset asserted mid-LOAD/SETTLE/RUN SHALL abort immediately to REQ-033 values next cycle.

Verification
REQ-037 Reset release, NUM_SECTIONS=4 -> addr 1000,1001,1002,1003 on cycles 1..4 with slot0=0x0FFFFFFF, others 0; then 4 cycles SETTLE; RUN.
REQ-038 In RUN, decim_n=5 -> axis_decii_clk pulses every 5 cycles; decim_n=0 -> pulses every cycle.
REQ-039 Write section 2 slot 4 = 0xF0000000, commit -> addr 1002 cycle carries 0xF0000000 in bits [159:128]; strobe silent until RUN.
REQ-040 Commit asserted on 2nd LOAD cycle -> full 4-section load repeats after SETTLE, then RUN.
REQ-041 Write wr_section=5 or wr_index=7, or write during LOAD -> table unchanged, wr_err=1 and stays 1 until reset.
REQ-042 Reset asserted on 3rd LOAD cycle -> next cycle config_addr=0, busy=0, axis_decii_clk=0; then auto-load of defaults.
